// File: rtl/arb_pkg.sv
// Shared types and helpers for the 2-requester arbiter and its grant/bus stages.
package arb_pkg;

   // Control states of the grant-to-bus burst controller.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      FIN  = 2'd2
   } state_t;

   // One-hot grant encodings as produced by the arbiter.
   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_R0   = 2'b01;
   localparam logic [1:0] GNT_R1   = 2'b10;
   localparam logic [1:0] GNT_BOTH = 2'b11;

   // Limit a requested burst length to the supported maximum; oversize
   // requests are quietly shortened rather than flagged.
   function automatic int unsigned clamp_len(input int unsigned len,
                                             input int unsigned max_burst);
      return (len > max_burst) ? max_burst : len;
   endfunction

endpackage

// File: rtl/arb_beat_counter.sv
// Beat counter for one burst: loads the burst length, advances on each
// accepted beat and flags when the beat on the bus is the final one.
module arb_beat_counter #(
   parameter int LEN_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [LEN_W-1:0] len,
   input  logic             accept,
   output logic             last
);

   logic [LEN_W-1:0] cnt_reg;
   logic [LEN_W-1:0] len_reg;

   // Load starts a new burst at beat 0; every accepted beat advances the count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_reg <= '0;
         len_reg <= '0;
      end else if (load) begin
         cnt_reg <= '0;
         len_reg <= len;
      end else if (accept) begin
         cnt_reg <= cnt_reg + LEN_W'(1);
      end
   end

   // Only meaningful while a non-empty burst is in flight.
   assign last = (cnt_reg == (len_reg - LEN_W'(1)));

endmodule

// File: rtl/arb_grant_bus_ctrl.sv
// Grant-to-bus controller: takes the arbiter's one-hot grant, moves the
// granted requester's data onto the shared target bus as a burst with a
// valid/ready handshake, and pulses per-requester completion.
// LEN_W must be wide enough that 2**LEN_W > MAX_BURST.
module arb_grant_bus_ctrl
   import arb_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4,
   parameter int LEN_W     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        grant,
   input  logic [DATA_W-1:0] req_data0,
   input  logic [DATA_W-1:0] req_data1,
   input  logic [LEN_W-1:0]  req_len0,
   input  logic [LEN_W-1:0]  req_len1,
   output logic              bus_valid,
   output logic [DATA_W-1:0] bus_data,
   input  logic              bus_ready,
   output logic [1:0]        bus_owner,
   output logic [1:0]        done,
   output logic              busy,
   output logic              err
);

   state_t            state_reg;
   logic              bus_valid_reg;
   logic [DATA_W-1:0] bus_data_reg;
   logic [1:0]        bus_owner_reg;
   logic [1:0]        done_reg;
   logic              busy_reg;
   logic              err_reg;

   logic [DATA_W-1:0] req_data_arr [2];
   logic [LEN_W-1:0]  req_len_arr  [2];
   logic [DATA_W-1:0] data_masked  [2];
   logic [LEN_W-1:0]  len_masked   [2];

   logic [1:0]        sel;
   logic [DATA_W-1:0] sel_data;
   logic [LEN_W-1:0]  sel_len;
   logic [LEN_W-1:0]  clamped_len;
   logic              grant_legal;
   logic              load;
   logic              accept;
   logic              last;
   logic              owner_lost;

   assign req_data_arr[0] = req_data0;
   assign req_data_arr[1] = req_data1;
   assign req_len_arr[0]  = req_len0;
   assign req_len_arr[1]  = req_len1;

   // In IDLE the incoming grant picks the source; once a burst is running
   // the captured owner does, so a changing grant cannot redirect the data.
   assign sel = (state_reg == IDLE) ? grant : bus_owner_reg;

   // One-hot AND-OR mux across the requesters.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sel
         assign data_masked[gi] = sel[gi] ? req_data_arr[gi] : '0;
         assign len_masked[gi]  = sel[gi] ? req_len_arr[gi]  : '0;
      end
   endgenerate

   assign sel_data    = data_masked[0] | data_masked[1];
   assign sel_len     = len_masked[0]  | len_masked[1];
   assign clamped_len = LEN_W'(clamp_len(32'(sel_len), MAX_BURST));

   assign grant_legal = (grant == GNT_R0) || (grant == GNT_R1);
   assign load        = (state_reg == IDLE) && grant_legal;
   assign accept      = (state_reg == XFER) && bus_valid_reg && bus_ready;
   assign owner_lost  = (grant != bus_owner_reg);

   arb_beat_counter #(
      .LEN_W (LEN_W)
   ) u_beat_counter (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .len    (clamped_len),
      .accept (accept),
      .last   (last)
   );

   // Burst sequencing with every output registered; done/err are one-cycle pulses.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= IDLE;
         bus_valid_reg <= 1'b0;
         bus_data_reg  <= '0;
         bus_owner_reg <= GNT_NONE;
         done_reg      <= GNT_NONE;
         busy_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         done_reg <= GNT_NONE;
         err_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (grant_legal) begin
                  bus_owner_reg <= grant;
                  busy_reg      <= 1'b1;
                  if (clamped_len != '0) begin
                     state_reg     <= XFER;
                     bus_valid_reg <= 1'b1;
                     bus_data_reg  <= sel_data;
                  end else begin
                     // Empty burst: complete straight away without a bus beat.
                     state_reg <= FIN;
                     done_reg  <= grant;
                  end
               end else if (grant == GNT_BOTH) begin
                  err_reg <= 1'b1;
               end
            end
            XFER: begin
               if (accept && last) begin
                  // Final beat wins over a simultaneous grant drop.
                  state_reg     <= FIN;
                  bus_valid_reg <= 1'b0;
                  done_reg      <= bus_owner_reg;
               end else if (owner_lost) begin
                  state_reg     <= FIN;
                  bus_valid_reg <= 1'b0;
                  done_reg      <= bus_owner_reg;
                  err_reg       <= 1'b1;
               end else if (accept) begin
                  bus_data_reg <= sel_data;
               end
            end
            FIN: begin
               state_reg     <= IDLE;
               bus_owner_reg <= GNT_NONE;
               busy_reg      <= 1'b0;
            end
            default: begin
               state_reg     <= IDLE;
               bus_valid_reg <= 1'b0;
               bus_owner_reg <= GNT_NONE;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign bus_valid = bus_valid_reg;
   assign bus_data  = bus_data_reg;
   assign bus_owner = bus_owner_reg;
   assign done      = done_reg;
   assign busy      = busy_reg;
   assign err       = err_reg;

endmodule

// File: tb/tb_arb_grant_bus_ctrl.sv
// Directed self-checking bench for the grant-to-bus burst controller.
module tb_arb_grant_bus_ctrl;

   localparam int DATA_W    = 8;
   localparam int MAX_BURST = 4;
   localparam int LEN_W     = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        grant;
   logic [DATA_W-1:0] req_data0;
   logic [DATA_W-1:0] req_data1;
   logic [LEN_W-1:0]  req_len0;
   logic [LEN_W-1:0]  req_len1;
   logic              bus_valid;
   logic [DATA_W-1:0] bus_data;
   logic              bus_ready;
   logic [1:0]        bus_owner;
   logic [1:0]        done;
   logic              busy;
   logic              err;

   int err_cnt = 0;
   int chk_cnt = 0;
   int beats   = 0;

   logic [1:0] d_seen;
   logic       e_seen;

   logic              bp_rdy  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
   logic [DATA_W-1:0] bp_data [4] = '{8'hB1, 8'hB3, 8'hB3, 8'hB3};

   arb_grant_bus_ctrl #(
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST),
      .LEN_W     (LEN_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .grant     (grant),
      .req_data0 (req_data0),
      .req_data1 (req_data1),
      .req_len0  (req_len0),
      .req_len1  (req_len1),
      .bus_valid (bus_valid),
      .bus_data  (bus_data),
      .bus_ready (bus_ready),
      .bus_owner (bus_owner),
      .done      (done),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; count a beat if valid&ready were high at that edge.
   task automatic step();
      logic acc;
      acc = bus_valid && bus_ready;
      @(posedge clk);
      #1;
      if (acc) beats++;
   endtask

   // Step until a done pulse appears or the cycle budget runs out.
   task automatic run_to_done(input int max_cyc, output logic [1:0] d, output logic e);
      d = 2'b00;
      e = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         step();
         if (err) e = 1'b1;
         if (done != 2'b00) begin
            d = done;
            break;
         end
      end
   endtask

   initial begin
      rst       = 1'b0;
      grant     = 2'b01;
      req_len0  = 3'd3;
      req_len1  = 3'd0;
      req_data0 = 8'h00;
      req_data1 = 8'h00;
      bus_ready = 1'b0;

      // Reset held two cycles with a grant present
      step();
      step();
      check("rst_valid", bus_valid, 0);
      check("rst_data",  bus_data,  0);
      check("rst_owner", bus_owner, 0);
      check("rst_done",  done,      0);
      check("rst_busy",  busy,      0);
      check("rst_err",   err,       0);
      $display("reset: valid=%0b owner=%0b busy=%0b", bus_valid, bus_owner, busy);
      rst   = 1'b1;
      grant = 2'b00;
      step();
      check("idle_busy", busy, 0);

      // Normal burst, requester 0, three beats
      beats     = 0;
      grant     = 2'b01;
      req_len0  = 3'd3;
      req_data0 = 8'hA1;
      bus_ready = 1'b1;
      step();
      check("nb_valid1", bus_valid, 1);
      check("nb_data1",  bus_data,  8'hA1);
      check("nb_owner",  bus_owner, 2'b01);
      check("nb_busy",   busy,      1);
      req_data0 = 8'hA2;
      step();
      check("nb_valid2", bus_valid, 1);
      check("nb_data2",  bus_data,  8'hA2);
      req_data0 = 8'hA3;
      step();
      check("nb_data3",  bus_data,  8'hA3);
      req_data0 = 8'hEE;
      step();
      check("nb_valid_end", bus_valid, 0);
      check("nb_done",      done,      2'b01);
      check("nb_owner_fin", bus_owner, 2'b01);
      check("nb_beats",     beats,     3);
      grant = 2'b00;
      step();
      check("nb_done_clr", done,      0);
      check("nb_owner_0",  bus_owner, 0);
      check("nb_busy_0",   busy,      0);
      $display("burst r0 len=3: beats=%0d", beats);

      // Backpressure, requester 1, two beats
      beats     = 0;
      grant     = 2'b10;
      req_len1  = 3'd2;
      req_data1 = 8'hB1;
      bus_ready = 1'b0;
      step();
      check("bp_owner", bus_owner, 2'b10);
      for (int i = 0; i < 4; i++) begin
         req_data1 = 8'hB2 + 8'(i);
         bus_ready = bp_rdy[i];
         step();
         check($sformatf("bp_valid%0d", i), bus_valid, 1);
         check($sformatf("bp_data%0d", i),  bus_data,  bp_data[i]);
      end
      req_data1 = 8'hB6;
      bus_ready = 1'b1;
      step();
      check("bp_valid_end", bus_valid, 0);
      check("bp_done",      done,      2'b10);
      check("bp_beats",     beats,     2);
      grant     = 2'b00;
      bus_ready = 1'b0;
      step();
      check("bp_done_clr", done, 0);
      $display("burst r1 len=2 backpressure: beats=%0d", beats);

      // Illegal double grant
      grant = 2'b11;
      step();
      check("ill_err",   err,       1);
      check("ill_busy",  busy,      0);
      check("ill_valid", bus_valid, 0);
      grant = 2'b00;
      step();
      check("ill_err_clr", err, 0);
      $display("grant=11: err pulse seen");

      // Zero-length burst
      beats     = 0;
      grant     = 2'b01;
      req_len0  = 3'd0;
      bus_ready = 1'b1;
      step();
      check("z_done",  done,      2'b01);
      check("z_valid", bus_valid, 0);
      check("z_busy",  busy,      1);
      grant = 2'b00;
      step();
      check("z_done_clr", done,  0);
      check("z_busy_0",   busy,  0);
      check("z_beats",    beats, 0);
      $display("burst r0 len=0: beats=%0d", beats);

      // Oversize length clamped to MAX_BURST
      beats    = 0;
      grant    = 2'b01;
      req_len0 = 3'd7;
      run_to_done(20, d_seen, e_seen);
      check("cl_done",  d_seen, 2'b01);
      check("cl_beats", beats,  MAX_BURST);
      check("cl_err",   e_seen, 0);
      grant = 2'b00;
      step();
      $display("burst r0 len=7 clamped: beats=%0d", beats);

      // Abort after two accepted beats
      beats    = 0;
      grant    = 2'b01;
      req_len0 = 3'd4;
      step();
      step();
      step();
      check("ab_beats_pre", beats,     2);
      check("ab_valid_pre", bus_valid, 1);
      grant     = 2'b00;
      bus_ready = 1'b0;
      step();
      check("ab_valid", bus_valid, 0);
      check("ab_err",   err,       1);
      check("ab_done",  done,      2'b01);
      check("ab_owner", bus_owner, 2'b01);
      step();
      check("ab_err_clr",  err,       0);
      check("ab_done_clr", done,      0);
      check("ab_busy_0",   busy,      0);
      check("ab_owner_0",  bus_owner, 0);
      $display("burst r0 aborted: beats=%0d", beats);

      // Grant drops on the same edge the last beat is accepted
      grant     = 2'b01;
      req_len0  = 3'd1;
      bus_ready = 1'b0;
      step();
      grant     = 2'b00;
      bus_ready = 1'b1;
      step();
      check("lg_done",  done,      2'b01);
      check("lg_err",   err,       0);
      check("lg_valid", bus_valid, 0);
      step();
      check("lg_busy_0", busy, 0);
      $display("burst r0 len=1 grant drop on last beat: done without err");

      // Reset during the second beat, then a fresh burst
      beats     = 0;
      grant     = 2'b01;
      req_len0  = 3'd3;
      req_data0 = 8'hC1;
      step();
      req_data0 = 8'hC2;
      step();
      check("rm_data2", bus_data, 8'hC2);
      rst = 1'b0;
      step();
      check("rm_valid", bus_valid, 0);
      check("rm_owner", bus_owner, 0);
      check("rm_done",  done,      0);
      check("rm_busy",  busy,      0);
      check("rm_err",   err,       0);
      rst       = 1'b1;
      req_len0  = 3'd2;
      req_data0 = 8'hD1;
      beats     = 0;
      step();
      check("rm_new_valid", bus_valid, 1);
      check("rm_new_data",  bus_data,  8'hD1);
      check("rm_new_owner", bus_owner, 2'b01);
      run_to_done(10, d_seen, e_seen);
      check("rm_new_done",  d_seen, 2'b01);
      check("rm_new_beats", beats,  2);
      grant = 2'b00;
      step();
      $display("reset mid-burst then fresh burst: beats=%0d", beats);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
